// File: rtl/dmem_bus_bridge.sv
// Data-side bridge: captures one core load/store, runs it on a single-outstanding bus, stalls the core until done.
// States: IDLE = waiting for core_req | REQ = bus_valid up, awaiting bus_ready | RSP = awaiting rsp_valid
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wmask,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_expired;

  assign w_expired  = (r_cnt == CNT_LAST);
  assign core_stall = (r_state == REQ) || (r_state == RSP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      core_rdata <= '0;
      core_err   <= 1'b0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      core_err <= 1'b0;
      if (r_state != IDLE && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (core_req) begin
            bus_we    <= core_we;
            bus_addr  <= core_addr & 32'hFFFF_FFFC;
            bus_wdata <= core_wdata;
            bus_wstrb <= core_we ? core_wmask : 4'b0000;
            bus_valid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= REQ;
          end
        end
        REQ: begin
          // An acceptance on the expiry edge cannot complete the access, so the timeout wins here.
          if (w_expired) begin
            bus_valid <= 1'b0;
            core_err  <= 1'b1;
            r_state   <= IDLE;
          end else if (bus_ready) begin
            bus_valid <= 1'b0;
            r_state   <= RSP;
          end
        end
        RSP: begin
          if (rsp_valid) begin
            if (!bus_we && !rsp_err)
              core_rdata <= rsp_rdata;
            core_err <= rsp_err;
            r_state  <= IDLE;
          end else if (w_expired) begin
            core_err <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: driver pushes expected bus requests and core responses, monitors pop and compare.
module tb_dmem_bus_bridge;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [3:0]  core_wmask = '0;
  logic [31:0] core_rdata;
  logic        core_stall, core_err;
  logic        bus_valid, bus_we;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [31:0] rsp_rdata = '0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wmask(core_wmask),
    .core_rdata(core_rdata), .core_stall(core_stall), .core_err(core_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct { logic [31:0] rdata; logic err; int stall; } rsp_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } bus_exp_t;

  rsp_exp_t    rq[$];
  bus_exp_t    bq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: stall length, read data and error pulse at the falling edge of stall.
  logic prev_stall = 1'b0;
  int   scnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      scnt = 0;
    end else begin
      if (core_stall) begin
        scnt++;
        chk("err_while_stalled", {31'b0, core_err}, 32'd0);
      end else if (prev_stall) begin
        if (rq.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          rsp_exp_t e;
          e = rq.pop_front();
          chk("stall_cycles", scnt, e.stall);
          chk("core_rdata", core_rdata, e.rdata);
          chk("core_err", {31'b0, core_err}, {31'b0, e.err});
        end
        scnt = 0;
      end else begin
        chk("err_while_idle", {31'b0, core_err}, 32'd0);
      end
      prev_stall = core_stall;
    end
  end

  // Bus monitor: request fields held stable for the whole time bus_valid is high.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus_valid) begin
        if (bq.size() == 0) begin
          chk("unexpected_bus_valid", 32'd1, 32'd0);
        end else begin
          chk("bus_we", {31'b0, bus_we}, {31'b0, bq[0].we});
          chk("bus_addr", bus_addr, bq[0].addr);
          chk("bus_wdata", bus_wdata, bq[0].wdata);
          chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, bq[0].strb});
        end
      end else if (prev_valid && bq.size() != 0) begin
        void'(bq.pop_front());
      end
      prev_valid = bus_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: bus_ready low for wr cycles, response wp cycles after acceptance.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int wr, input int wp,
                        input logic [31:0] rd, input logic rerr);
    int       total;
    bit       to;
    bus_exp_t b;
    rsp_exp_t r;
    total = wr + wp + 2;
    to = (total > TO) || (wr + 1 >= TO);
    b.we = we; b.addr = {addr[31:2], 2'b00}; b.wdata = wdata; b.strb = we ? wmask : 4'b0000;
    bq.push_back(b);
    if (!to && !we && !rerr) m_rdata = rd;
    r.rdata = m_rdata;
    r.err = to ? 1'b1 : rerr;
    r.stall = to ? TO : total;
    rq.push_back(r);

    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_wmask = wmask;
    tick();
    chk("stall_after_capture", {31'b0, core_stall}, 32'd1);
    core_req = 1'b0;
    for (int k = 0; k < wr; k++) begin
      bus_ready = 1'b0;
      if (!to) begin
        core_req = 1'($urandom); core_we = 1'($urandom);
        core_addr = $urandom; core_wdata = $urandom; core_wmask = 4'($urandom);
      end
      rsp_valid = 1'($urandom); rsp_rdata = $urandom; rsp_err = 1'($urandom);
      tick();
    end
    core_req = 1'b0;
    rsp_valid = 1'b0;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    for (int k = 0; k < wp; k++) tick();
    rsp_valid = 1'b1; rsp_rdata = rd; rsp_err = rerr;
    tick();
    rsp_valid = 1'b0; rsp_rdata = $urandom; rsp_err = 1'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, core_rdata, 32'd0);
    chk({tag, "_err"}, {31'b0, core_err}, 32'd0);
    chk({tag, "_stall"}, {31'b0, core_stall}, 32'd0);
    chk({tag, "_valid"}, {31'b0, bus_valid}, 32'd0);
    chk({tag, "_we"}, {31'b0, bus_we}, 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_wstrb"}, {28'b0, bus_wstrb}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_exp_t b;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    access(1'b0, 32'h0000_1006, 32'h5555_AAAA, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0);
    tick();
    access(1'b1, 32'h0000_2000, 32'h1234_0000, 4'b1100, 3, 1, 32'hCAFE_F00D, 1'b0);
    tick();
    access(1'b0, 32'h0000_3003, 32'h0, 4'h0, 1, 0, 32'h0BAD_0BAD, 1'b1);
    tick();
    access(1'b0, 32'h0000_4004, 32'h0, 4'h0, 3, 3, 32'h0A0B_0C0D, 1'b0);
    tick();
    access(1'b0, 32'h0000_5005, 32'h0, 4'h0, 20, 0, 32'hFFFF_FFFF, 1'b0);
    repeat (3) tick();
    chk("after_timeout_stall", {31'b0, core_stall}, 32'd0);
    chk("after_timeout_valid", {31'b0, bus_valid}, 32'd0);
    chk("after_timeout_rdata", core_rdata, 32'h0A0B_0C0D);

    access(1'b0, 32'h0000_6000, 32'h0, 4'h0, 0, 0, 32'h1111_2222, 1'b0);
    access(1'b0, 32'h0000_6004, 32'h0, 4'h0, 0, 0, 32'h3333_4444, 1'b0);
    tick();

    b.we = 1'b0; b.addr = 32'h0000_7008; b.wdata = 32'h0; b.strb = 4'h0;
    bq.push_back(b);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_7008; core_wdata = 32'h0; core_wmask = 4'h0;
    tick();
    core_req = 1'b0;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    chk("stall_in_rsp", {31'b0, core_stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    rq.delete();
    bq.delete();
    m_rdata = '0;
    tick();
    reset = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_rdata = 32'h9999_9999; rsp_err = 1'b0;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("stale_rsp_ignored", core_rdata, 32'd0);
    access(1'b0, 32'h0000_8000, 32'h0, 4'h0, 1, 1, 32'h7777_8888, 1'b0);

    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        core_we = 1'($urandom); core_addr = $urandom;
        tick();
      end
      access(1'($urandom), $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
             ($urandom_range(0, 7) == 0));
    end

    repeat (4) tick();
    chk("rsp_queue_empty", rq.size(), 32'd0);
    chk("bus_queue_empty", bq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
